// File: rtl/rv32i_pkg.sv
// Shared types and helpers for the performance-counter bank.
//   perf_state_e : control FSM states (IDLE, RUN)
//   PERF_MAX_CH  : upper bound on the number of event channels
//   perf_idx_w   : width of a channel index for n channels (at least 1 bit)
package rv32i_pkg;

  localparam int unsigned PERF_MAX_CH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } perf_state_e;

  function automatic int unsigned perf_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// One channel of the performance-counter bank: live counter, shadow copy and
// sticky overflow flag.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : zero live counter and overflow flag (wins over counting)
//   i_inc        : count one event this cycle
//   i_cap        : copy the current (pre-increment) live value to the shadow
//   i_restart    : window boundary; live restarts at this cycle's event (0/1)
//   o_live       : live counter
//   o_shadow     : shadow register
//   o_ovf        : sticky wrap/saturation flag
module perf_cnt_cell import rv32i_pkg::*; #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_cap,
  input  logic             i_restart,
  output logic [CNT_W-1:0] o_live,
  output logic [CNT_W-1:0] o_shadow,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counter, shadow and overflow update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_live   <= '0;
      o_shadow <= '0;
      o_ovf    <= 1'b0;
    end else begin
      if (i_cap) begin
        o_shadow <= o_live;
      end
      if (i_clr) begin
        o_live <= '0;
        o_ovf  <= 1'b0;
      end else if (i_restart) begin
        o_live <= CNT_W'(i_inc);
      end else if (i_inc) begin
        if (o_live == CNT_MAX) begin
          // Wrap mode rolls over; saturate mode holds at all-ones.
          o_ovf <= 1'b1;
          if (SATURATE == 0) begin
            o_live <= '0;
          end
        end else begin
          o_live <= o_live + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/perf_cnt_bank.sv
// Bank of NUM_CH event counters with start/stop control, manual and windowed
// snapshots to shadow registers, and a 1-cycle-latency read port.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_evt                 : per-channel event strobes
//   i_start/i_stop        : enter/leave RUN (stop wins when both)
//   i_clr                 : zero live counters, overflow flags, window count
//   i_snap                : copy all live counters to shadows
//   i_win_len             : auto-snapshot period (0 = off), latched on start
//   i_rd_req/idx/shadow   : read request, channel, live/shadow select
//   o_rd_vld, o_rd_data   : read response one cycle after the request
//   o_ovf                 : sticky per-channel overflow flags
//   o_win_done            : pulse one cycle after a window auto-snapshot
//   o_running             : high while in RUN
module perf_cnt_bank import rv32i_pkg::*; #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned WIN_W    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_evt,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_clr,
  input  logic                          i_snap,
  input  logic [WIN_W-1:0]              i_win_len,
  input  logic                          i_rd_req,
  input  logic [perf_idx_w(NUM_CH)-1:0] i_rd_idx,
  input  logic                          i_rd_shadow,
  output logic                          o_rd_vld,
  output logic [CNT_W-1:0]              o_rd_data,
  output logic [NUM_CH-1:0]             o_ovf,
  output logic                          o_win_done,
  output logic                          o_running
);

  localparam int unsigned IDX_W = perf_idx_w(NUM_CH);

  perf_state_e      state;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] live   [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];

  logic             run_c;
  logic             boundary_c;
  logic             auto_snap_c;
  logic             cap_c;
  logic [CNT_W-1:0] rd_val_c;

  // win_cnt holds completed cycles of the current window, so cycle N is N-1.
  assign run_c       = (state == RUN);
  assign boundary_c  = run_c && (win_len_q != '0) &&
                       (win_cnt == win_len_q - WIN_W'(1));
  assign auto_snap_c = boundary_c && !i_clr;
  assign cap_c       = i_snap || auto_snap_c;

  // Control FSM, window counter and status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      win_len_q  <= '0;
      win_cnt    <= '0;
      o_running  <= 1'b0;
      o_win_done <= 1'b0;
    end else begin
      o_win_done <= auto_snap_c;
      if (i_clr) begin
        win_cnt <= '0;
      end else if (run_c && (win_len_q != '0)) begin
        win_cnt <= auto_snap_c ? '0 : win_cnt + WIN_W'(1);
      end
      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            state     <= RUN;
            o_running <= 1'b1;
            win_len_q <= i_win_len;
            win_cnt   <= '0;
          end
        end
        RUN: begin
          if (i_stop) begin
            state     <= IDLE;
            o_running <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          o_running <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel counter cells
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cell
    perf_cnt_cell #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cell (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (i_clr),
      .i_inc    (run_c && i_evt[k]),
      .i_cap    (cap_c),
      .i_restart(auto_snap_c),
      .o_live   (live[k]),
      .o_shadow (shadow[k]),
      .o_ovf    (o_ovf[k])
    );
  end

  // Read mux; indices with no channel behind them read as zero
  always_comb begin
    rd_val_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_rd_idx == IDX_W'(k)) begin
        rd_val_c = i_rd_shadow ? shadow[k] : live[k];
      end
    end
  end

  // Read response register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_vld  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_rd_vld  <= i_rd_req;
      o_rd_data <= i_rd_req ? rd_val_c : '0;
    end
  end

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Bench for perf_cnt_bank: three 8-bit instances (4ch wrap, 4ch saturate,
// 3ch wrap) share stimulus and are checked every cycle against a reference
// model, plus fixed expectations for the directed scenarios.
module tb_perf_cnt_bank;

  localparam int unsigned ND   = 3;
  localparam int unsigned MAXV = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, clr, snap, rd_req, rd_shadow;
  logic [3:0]  evt;
  logic [15:0] win_len;
  logic [1:0]  rd_idx;

  logic        rd_vld   [ND];
  logic [7:0]  rd_data  [ND];
  logic        win_done [ND];
  logic        running  [ND];
  logic [3:0]  ovf_v    [ND];
  logic [3:0]  ovf_a, ovf_b;
  logic [2:0]  ovf_c;

  assign ovf_v[0] = ovf_a;
  assign ovf_v[1] = ovf_b;
  assign ovf_v[2] = {1'b0, ovf_c};

  perf_cnt_bank #(.NUM_CH(4), .CNT_W(8), .SATURATE(0), .WIN_W(16)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_evt(evt), .i_start(start), .i_stop(stop),
    .i_clr(clr), .i_snap(snap), .i_win_len(win_len), .i_rd_req(rd_req),
    .i_rd_idx(rd_idx), .i_rd_shadow(rd_shadow), .o_rd_vld(rd_vld[0]),
    .o_rd_data(rd_data[0]), .o_ovf(ovf_a), .o_win_done(win_done[0]),
    .o_running(running[0]));

  perf_cnt_bank #(.NUM_CH(4), .CNT_W(8), .SATURATE(1), .WIN_W(16)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_evt(evt), .i_start(start), .i_stop(stop),
    .i_clr(clr), .i_snap(snap), .i_win_len(win_len), .i_rd_req(rd_req),
    .i_rd_idx(rd_idx), .i_rd_shadow(rd_shadow), .o_rd_vld(rd_vld[1]),
    .o_rd_data(rd_data[1]), .o_ovf(ovf_b), .o_win_done(win_done[1]),
    .o_running(running[1]));

  perf_cnt_bank #(.NUM_CH(3), .CNT_W(8), .SATURATE(0), .WIN_W(16)) u_ch3 (
    .i_clk(clk), .i_rst(rst), .i_evt(evt[2:0]), .i_start(start), .i_stop(stop),
    .i_clr(clr), .i_snap(snap), .i_win_len(win_len), .i_rd_req(rd_req),
    .i_rd_idx(rd_idx), .i_rd_shadow(rd_shadow), .o_rd_vld(rd_vld[2]),
    .o_rd_data(rd_data[2]), .o_ovf(ovf_c), .o_win_done(win_done[2]),
    .o_running(running[2]));

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model state
  int unsigned nch [ND] = '{4, 4, 3};
  bit          sat [ND] = '{1'b0, 1'b1, 1'b0};
  int unsigned m_live   [ND][4];
  int unsigned m_shadow [ND][4];
  bit          m_ovf    [ND][4];
  int unsigned m_data   [ND];
  bit          m_run, m_vld, m_done;
  int unsigned m_wlen, m_wcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit wrap_now, auto_now, e;
    if (rst) begin
      for (int d = 0; d < ND; d++) begin
        m_data[d] = 0;
        for (int k = 0; k < 4; k++) begin
          m_live[d][k] = 0; m_shadow[d][k] = 0; m_ovf[d][k] = 0;
        end
      end
      m_run = 0; m_vld = 0; m_done = 0; m_wlen = 0; m_wcnt = 0;
      return;
    end
    m_vld = rd_req;
    for (int d = 0; d < ND; d++) begin
      if (rd_req && (int'(rd_idx) < int'(nch[d])))
        m_data[d] = rd_shadow ? m_shadow[d][rd_idx] : m_live[d][rd_idx];
      else
        m_data[d] = 0;
    end
    wrap_now = m_run && (m_wlen != 0) && (m_wcnt + 1 == m_wlen);
    auto_now = wrap_now && !clr;
    m_done   = auto_now;
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < int'(nch[d]); k++) begin
        e = m_run && evt[k];
        if (snap || auto_now) m_shadow[d][k] = m_live[d][k];
        if (clr) begin
          m_live[d][k] = 0;
          m_ovf[d][k]  = 0;
        end else if (auto_now) begin
          m_live[d][k] = e ? 1 : 0;
        end else if (e) begin
          if (m_live[d][k] == MAXV) begin
            m_ovf[d][k] = 1;
            if (!sat[d]) m_live[d][k] = 0;
          end else begin
            m_live[d][k] = m_live[d][k] + 1;
          end
        end
      end
    end
    if (clr) m_wcnt = 0;
    else if (m_run && m_wlen != 0) m_wcnt = auto_now ? 0 : m_wcnt + 1;
    if (!m_run && start && !stop) begin
      m_run = 1; m_wlen = win_len; m_wcnt = 0;
    end else if (m_run && stop) begin
      m_run = 0;
    end
  endtask

  // One clock: update model, compare all outputs, drop single-cycle pulses.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [3:0] ov;
      ov = '0;
      for (int k = 0; k < int'(nch[d]); k++) ov[k] = m_ovf[d][k];
      check($sformatf("running[%0d]", d),  32'(running[d]),  32'(m_run));
      check($sformatf("win_done[%0d]", d), 32'(win_done[d]), 32'(m_done));
      check($sformatf("rd_vld[%0d]", d),   32'(rd_vld[d]),   32'(m_vld));
      check($sformatf("rd_data[%0d]", d),  32'(rd_data[d]),  m_data[d]);
      check($sformatf("ovf[%0d]", d),      32'(ovf_v[d]),    32'(ov));
    end
    if (win_done[0]) done_cnt++;
    start = 0; stop = 0; clr = 0; snap = 0; rd_req = 0;
  endtask

  task automatic read_chk(input string tag, input int idx, input bit sh,
                          input int e0, input int e1, input int e2);
    rd_req = 1; rd_idx = 2'(idx); rd_shadow = sh;
    tick();
    check({tag, "_vld"}, 32'(rd_vld[0]), 32'd1);
    check({tag, "_wrap"}, 32'(rd_data[0]), 32'(e0));
    check({tag, "_sat"},  32'(rd_data[1]), 32'(e1));
    check({tag, "_ch3"},  32'(rd_data[2]), 32'(e2));
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; clr = 0; snap = 0; rd_req = 0; rd_shadow = 0;
    evt = '0; win_len = '0; rd_idx = '0;
    tick(); tick();
    rst = 0;
    check("reset_running", 32'(running[0]), 32'd0);
    check("reset_rd_vld",  32'(rd_vld[0]),  32'd0);

    // Basic counting
    start = 1; tick();
    evt = 4'b0101;
    repeat (10) tick();
    evt = '0; stop = 1; tick();
    read_chk("basic_ch0", 0, 0, 10, 10, 10);
    tick();
    check("rd_vld_one_cycle", 32'(rd_vld[0]), 32'd0);
    read_chk("basic_ch1", 1, 0, 0, 0, 0);
    read_chk("basic_ch2", 2, 0, 10, 10, 10);

    // Wrap vs saturate on ch3; the 3-channel bank reads index 3 as zero
    clr = 1; tick();
    start = 1; tick();
    evt = 4'b1000;
    repeat (257) tick();
    evt = '0; stop = 1; tick();
    read_chk("ovf_ch3", 3, 0, 1, 255, 0);
    check("ovf_flag_wrap", 32'(ovf_v[0][3]), 32'd1);
    check("ovf_flag_sat",  32'(ovf_v[1][3]), 32'd1);
    clr = 1; tick();
    read_chk("clr_ch3", 3, 0, 0, 0, 0);
    check("clr_ovf_wrap", 32'(ovf_v[0]), 32'd0);
    check("clr_ovf_sat",  32'(ovf_v[1]), 32'd0);

    // Windowing; window length changes during RUN must be ignored
    win_len = 16'd8; start = 1; tick();
    win_len = '0; evt = 4'b0001; done_cnt = 0;
    repeat (24) tick();
    check("win_pulses", 32'(done_cnt), 32'd3);
    evt = '0; stop = 1; tick();
    read_chk("win_live", 0, 0, 1, 1, 1);
    read_chk("win_shadow", 0, 1, 8, 8, 8);

    // Manual snapshot with a coincident event
    clr = 1; tick();
    start = 1; tick();
    evt = 4'b0001;
    repeat (5) tick();
    snap = 1; tick();
    evt = '0; stop = 1; tick();
    read_chk("snap_live", 0, 0, 6, 6, 6);
    read_chk("snap_shadow", 0, 1, 5, 5, 5);

    // Manual snapshot on a window boundary
    win_len = 16'd8; start = 1; tick();
    win_len = '0; done_cnt = 0;
    repeat (7) tick();
    snap = 1; tick();
    tick(); tick();
    check("snap_win_pulses", 32'(done_cnt), 32'd1);
    stop = 1; tick();
    read_chk("snap_win_shadow", 0, 1, 6, 6, 6);

    // Clear on a window boundary suppresses the auto-snapshot
    win_len = 16'd8; start = 1; tick();
    win_len = '0; evt = 4'b0011; done_cnt = 0;
    repeat (7) tick();
    clr = 1; tick();
    evt = '0;
    repeat (3) tick();
    check("clr_win_pulses", 32'(done_cnt), 32'd0);
    stop = 1; tick();
    read_chk("clr_win_live", 0, 0, 0, 0, 0);
    read_chk("clr_win_shadow", 0, 1, 6, 6, 6);
    start = 1; stop = 1; tick();
    check("start_stop_idle", 32'(running[0]), 32'd0);

    // Reset mid-run with a read in flight
    start = 1; tick();
    evt = 4'b1111;
    repeat (5) tick();
    rst = 1; rd_req = 1; rd_idx = 2'd0; rd_shadow = 0; tick();
    check("rst_rd_vld",  32'(rd_vld[0]),  32'd0);
    check("rst_running", 32'(running[0]), 32'd0);
    rst = 0; evt = '0;
    read_chk("rst_live0", 0, 0, 0, 0, 0);
    read_chk("rst_live3", 3, 0, 0, 0, 0);
    read_chk("rst_shadow0", 0, 1, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 699) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      clr       = ($urandom_range(0, 399) == 0);
      snap      = ($urandom_range(0, 9) == 0);
      evt       = 4'($urandom) | 4'($urandom);
      win_len   = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      rd_req    = 1'($urandom_range(0, 1));
      rd_idx    = 2'($urandom);
      rd_shadow = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
